// File: rtl/one_four_demux_stream.sv
// Registered 1:4 stream demultiplexer: packets from one valid/ready input are
// steered to one of four lanes, each with its own one-entry output register.
module one_four_demux_stream #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         sel,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               din_last,
  output logic               din_ready,
  output logic [4*WIDTH-1:0] dout,
  output logic [3:0]         dout_valid,
  output logic [3:0]         dout_last,
  input  logic [3:0]         dout_ready,
  output logic               busy,
  output logic [1:0]         lane
);

  // Handshake: a beat transfers on any rising edge where valid and ready are
  // both high; valid never waits on ready, and a holder keeps data/last
  // stable while valid is high and ready is low.

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] lock_sel;
  logic [1:0] lock_next;
  logic [1:0] tgt;
  logic       accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= 2'd0;
    end else begin
      state    <= state_next;
      lock_sel <= lock_next;
    end
  end

  // The target lane only looks at sel on the first beat; once a packet is
  // in flight the locked lane is used so a packet never splits.
  always_comb begin
    tgt        = (state == ROUTE) ? lock_sel : sel;
    din_ready  = ~dout_valid[tgt] | dout_ready[tgt];
    accept     = din_valid & din_ready;
    state_next = state;
    lock_next  = lock_sel;
    case (state)
      IDLE: begin
        if (accept && !din_last) begin
          state_next = ROUTE;
          lock_next  = sel;
        end
      end
      ROUTE: begin
        if (accept && din_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == ROUTE);
  assign lane = tgt;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic             push;
    logic             valid_q;
    logic             last_q;
    logic [WIDTH-1:0] data_q;

    assign push = accept && (tgt == 2'(i));

    // Push wins over pop so a full lane that drains and refills in the
    // same cycle keeps streaming one beat per clock.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
      end else if (push) begin
        valid_q <= 1'b1;
        last_q  <= din_last;
        data_q  <= din;
      end else if (dout_ready[i]) begin
        valid_q <= 1'b0;
      end
    end

    assign dout_valid[i]              = valid_q;
    assign dout_last[i]               = last_q;
    assign dout[i*WIDTH +: WIDTH]     = data_q;
  end

endmodule

// File: tb/tb_one_four_demux_stream.sv
// Bench for one_four_demux_stream: directed scenarios plus randomized packets,
// checked by per-lane expected queues filled when packets are issued.
module tb_one_four_demux_stream;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     sel;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           din_last;
  logic           din_ready;
  logic [4*W-1:0] dout;
  logic [3:0]     dout_valid;
  logic [3:0]     dout_last;
  logic [3:0]     dout_ready;
  logic           busy;
  logic [1:0]     lane;

  one_four_demux_stream #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sel(sel), .din(din), .din_valid(din_valid),
    .din_last(din_last), .din_ready(din_ready), .dout(dout),
    .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
    .busy(busy), .lane(lane)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  bit rand_mode = 1'b0;
  always @(posedge clk) cyc++;

  // Expected beats per lane: {last, data}, pushed in packet order at issue.
  logic [W:0]   exp_q [4][$];
  logic [W-1:0] pkt_data [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Random consumer backpressure.
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      dout_ready = 4'($urandom_range(0, 15));
    end
  end

  // Monitor: compares each popped beat and checks stall stability.
  logic [W:0] held [4];
  bit         stall [4];
  logic [W:0] act;
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stall[i] = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        act = {dout_last[i], dout[i*W +: W]};
        if (stall[i]) chk($sformatf("hold_lane%0d", i), {dout_valid[i], act}, {1'b1, held[i]});
        stall[i] = dout_valid[i] && !dout_ready[i];
        held[i]  = act;
        if (dout_valid[i] && dout_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat lane%0d: got %0h expected none", i, act);
          end else begin
            chk($sformatf("beat_lane%0d", i), act, exp_q[i].pop_front());
          end
        end
      end
    end
  end

  // Driver: issues n_send beats of a len-beat packet to lane ln. sel_after<0
  // scrambles sel after the first beat; otherwise sel is forced to it.
  task automatic send_packet(input int ln, input int len, input int sel_after, input int n_send);
    logic [W-1:0] d;
    int t;
    for (int b = 0; b < n_send; b++) begin
      d = W'($urandom);
      pkt_data[b] = d;
      sel = (b == 0) ? 2'(ln) : (sel_after < 0 ? 2'($urandom_range(0, 3)) : 2'(sel_after));
      din = d;
      din_last = (b == len - 1);
      din_valid = 1'b1;
      exp_q[ln].push_back({din_last, d});
      t = 0;
      @(negedge clk);
      while (!din_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        chk("accept_timeout", 0, 1);
        din_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      if (b < len - 1) begin
        chk("busy_mid", busy, 1);
        chk("lane_lock", lane, ln);
      end else begin
        chk("busy_end", busy, 0);
      end
    end
  endtask

  logic [W-1:0] saved;
  int c0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 2'd0; din = '0; din_valid = 1'b0; din_last = 1'b0;
    dout_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_din_ready", din_ready, 1);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("idle_lane_eq_sel", lane, s);
    end
    @(posedge clk); #1;

    // single-beat packet to lane 2
    dout_ready = 4'b1111;
    send_packet(2, 1, -1, 1);
    @(negedge clk);
    chk("t2_valid", dout_valid, 4'b0100);
    chk("t2_last", dout_last, 4'b0100);
    chk("t2_data", dout[11:8], pkt_data[0]);
    chk("t2_busy", busy, 0);
    @(posedge clk); #1;

    // 3-beat packet on lane 1 while sel moves to 3
    send_packet(1, 3, 3, 3);
    repeat (3) @(posedge clk); #1;

    // lane 0 stalled during a 2-beat packet
    dout_ready = 4'b1110;
    fork
      send_packet(0, 2, -1, 2);
      begin
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("t4_din_ready", din_ready, 0);
        chk("t4_hold", {dout_valid[0], dout[3:0]}, {1'b1, pkt_data[0]});
        @(posedge clk); #1;
        dout_ready = 4'b1111;
      end
    join
    @(negedge clk);
    chk("t4_beat2", {dout_valid[0], dout_last[0], dout[3:0]}, {2'b11, pkt_data[1]});
    @(posedge clk); #1;

    // lane 3 stalled while lane 1 streams
    dout_ready = 4'b0111;
    send_packet(3, 1, -1, 1);
    saved = pkt_data[0];
    c0 = cyc;
    send_packet(1, 4, -1, 4);
    chk("t5_rate", cyc - c0, 4);
    chk("t5_lane3", {dout_valid[3], dout_last[3], dout[15:12]}, {2'b11, saved});
    dout_ready = 4'b1111;
    repeat (3) @(posedge clk); #1;

    // reset in the middle of a packet
    send_packet(2, 4, -1, 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_valid", dout_valid, 0);
    chk("t6_busy", busy, 0);
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send_packet(0, 2, -1, 2);
    repeat (3) @(posedge clk); #1;

    // randomized packets under random backpressure
    rand_mode = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(1, 4);
      send_packet($urandom_range(0, 3), len, -1, len);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_mode = 1'b0;
    @(posedge clk); #2;
    dout_ready = 4'b1111;
    repeat (5) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk($sformatf("drained_lane%0d", i), exp_q[i].size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
